// File: rtl/traffic_phase_sched.sv
// -----------------------------------------------------------------------------
// traffic_phase_sched
//
// Timed phase scheduler for a two-road intersection (road A / road B).
// Sequences the signal heads through green, yellow and all-red phases,
// enforces minimum and maximum green times, arbitrates vehicle-sensor demand
// and latched pedestrian requests, and drives lamp and walk outputs directly.
// All timing counts in units of the single-cycle `tick` enable.
//
// Ports:
//   clk     in   system clock
//   reset   in   synchronous active-low reset (0 = reset)
//   tick    in   time-base enable, single-cycle pulse
//   Ta, Tb  in   vehicle present on road A / road B
//   pa_req  in   pedestrian request to walk with road A green (pulse or level)
//   pb_req  in   pedestrian request to walk with road B green
//   La, Lb  out  lamp for road A / B: 00 GREEN, 01 YELLOW, 10 RED
//   walk_a  out  walk indication for the road A crossing
//   walk_b  out  walk indication for the road B crossing
//   phase   out  current FSM state (debug)
// -----------------------------------------------------------------------------
module traffic_phase_sched #(
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned MIN_GREEN = 5,
    parameter int unsigned MAX_GREEN = 12,
    parameter int unsigned YELLOW_T  = 3,
    parameter int unsigned ALLRED_T  = 1,
    parameter int unsigned WALK_T    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       Ta,
    input  logic       Tb,
    input  logic       pa_req,
    input  logic       pb_req,
    output logic [1:0] La,
    output logic [1:0] Lb,
    output logic       walk_a,
    output logic       walk_b,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        A_GREEN  = 3'b000,
        A_YELLOW = 3'b001,
        AB_RED   = 3'b010,
        B_GREEN  = 3'b011,
        B_YELLOW = 3'b100,
        BA_RED   = 3'b101
    } state_e;

    localparam logic [1:0] LAMP_GREEN  = 2'b00;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_RED    = 2'b10;

    localparam logic [CNT_W-1:0] MIN_GREEN_C = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] MAX_GREEN_C = CNT_W'(MAX_GREEN);
    localparam logic [CNT_W-1:0] YELLOW_C    = CNT_W'(YELLOW_T);
    localparam logic [CNT_W-1:0] ALLRED_C    = CNT_W'(ALLRED_T);
    localparam logic [CNT_W-1:0] WALK_C      = CNT_W'(WALK_T);
    localparam logic [CNT_W-1:0] ELAPSED_MAX = {CNT_W{1'b1}};

    // Lamp decode of a state code: {La, Lb}. Unused codes show all-red so a
    // corrupted state never lights a green.
    function automatic logic [3:0] lamp_decode(input logic [2:0] st);
        logic [3:0] lamps;
        case (st)
            3'b000:  lamps = {LAMP_GREEN,  LAMP_RED};
            3'b001:  lamps = {LAMP_YELLOW, LAMP_RED};
            3'b010:  lamps = {LAMP_RED,    LAMP_RED};
            3'b011:  lamps = {LAMP_RED,    LAMP_GREEN};
            3'b100:  lamps = {LAMP_RED,    LAMP_YELLOW};
            3'b101:  lamps = {LAMP_RED,    LAMP_RED};
            default: lamps = {LAMP_RED,    LAMP_RED};
        endcase
        return lamps;
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] elapsed_q, elapsed_d;
    logic             pa_pend_q, pa_pend_d;
    logic             pb_pend_q, pb_pend_d;
    logic             walk_a_flag_q, walk_a_flag_d;
    logic             walk_b_flag_q, walk_b_flag_d;

    logic             demand_a_s;
    logic             demand_b_s;
    logic             enter_a_s;
    logic             enter_b_s;
    logic [3:0]       lamps_s;

    assign demand_a_s = Ta | pa_pend_q;
    assign demand_b_s = Tb | pb_pend_q;

    // Next-state logic: phase transitions judged on the registered elapsed count.
    always_comb begin
        state_d = state_q;
        case (state_q)
            A_GREEN: begin
                // A holds green while B has no demand; a waiting A vehicle
                // only extends the green up to MAX_GREEN.
                if ((elapsed_q >= MIN_GREEN_C) && demand_b_s &&
                    (!Ta || (elapsed_q >= MAX_GREEN_C))) begin
                    state_d = A_YELLOW;
                end else begin
                    state_d = A_GREEN;
                end
            end
            A_YELLOW: begin
                if (elapsed_q >= YELLOW_C) begin
                    state_d = AB_RED;
                end else begin
                    state_d = A_YELLOW;
                end
            end
            AB_RED: begin
                if (elapsed_q >= ALLRED_C) begin
                    state_d = B_GREEN;
                end else begin
                    state_d = AB_RED;
                end
            end
            B_GREEN: begin
                if ((elapsed_q >= MIN_GREEN_C) && demand_a_s &&
                    (!Tb || (elapsed_q >= MAX_GREEN_C))) begin
                    state_d = B_YELLOW;
                end else begin
                    state_d = B_GREEN;
                end
            end
            B_YELLOW: begin
                if (elapsed_q >= YELLOW_C) begin
                    state_d = BA_RED;
                end else begin
                    state_d = B_YELLOW;
                end
            end
            BA_RED: begin
                if (elapsed_q >= ALLRED_C) begin
                    state_d = A_GREEN;
                end else begin
                    state_d = BA_RED;
                end
            end
            default: state_d = A_GREEN;
        endcase
    end

    assign enter_a_s = (state_q == BA_RED) && (state_d == A_GREEN);
    assign enter_b_s = (state_q == AB_RED) && (state_d == B_GREEN);

    // Elapsed-tick counter, pedestrian latches and walk flags.
    always_comb begin
        elapsed_d     = elapsed_q;
        pa_pend_d     = pa_pend_q;
        pb_pend_d     = pb_pend_q;
        walk_a_flag_d = walk_a_flag_q;
        walk_b_flag_d = walk_b_flag_q;

        // A phase change restarts timing even on a tick cycle.
        if (state_d != state_q) begin
            elapsed_d = '0;
        end else if (tick && (elapsed_q != ELAPSED_MAX)) begin
            elapsed_d = elapsed_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            elapsed_d = elapsed_q;
        end

        // Serving a request wins over a new request in the same cycle.
        if (enter_a_s) begin
            pa_pend_d = 1'b0;
        end else if (pa_req) begin
            pa_pend_d = 1'b1;
        end else begin
            pa_pend_d = pa_pend_q;
        end

        if (enter_b_s) begin
            pb_pend_d = 1'b0;
        end else if (pb_req) begin
            pb_pend_d = 1'b1;
        end else begin
            pb_pend_d = pb_pend_q;
        end

        if (enter_a_s) begin
            walk_a_flag_d = pa_pend_q;
        end else if (state_d != A_GREEN) begin
            walk_a_flag_d = 1'b0;
        end else begin
            walk_a_flag_d = walk_a_flag_q;
        end

        if (enter_b_s) begin
            walk_b_flag_d = pb_pend_q;
        end else if (state_d != B_GREEN) begin
            walk_b_flag_d = 1'b0;
        end else begin
            walk_b_flag_d = walk_b_flag_q;
        end
    end

    // State and timing registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= A_GREEN;
            elapsed_q     <= '0;
            pa_pend_q     <= 1'b0;
            pb_pend_q     <= 1'b0;
            walk_a_flag_q <= 1'b0;
            walk_b_flag_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            elapsed_q     <= elapsed_d;
            pa_pend_q     <= pa_pend_d;
            pb_pend_q     <= pb_pend_d;
            walk_a_flag_q <= walk_a_flag_d;
            walk_b_flag_q <= walk_b_flag_d;
        end
    end

    // Moore output decode straight from the registered state.
    always_comb begin
        lamps_s = lamp_decode(state_q);
        La      = lamps_s[3:2];
        Lb      = lamps_s[1:0];
        walk_a  = (state_q == A_GREEN) && walk_a_flag_q && (elapsed_q < WALK_C);
        walk_b  = (state_q == B_GREEN) && walk_b_flag_q && (elapsed_q < WALK_C);
        phase   = state_q;
    end

endmodule

// File: tb/tb_traffic_phase_sched.sv
// -----------------------------------------------------------------------------
// Testbench for traffic_phase_sched (default parameters).
// Each vector drives one clock cycle of inputs and, when checked, compares the
// outputs visible during that cycle against hand-computed expectations.
// Cycle 0 of a scenario is the first cycle after the reset vector.
// -----------------------------------------------------------------------------
module tb_traffic_phase_sched;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       Ta;
    logic       Tb;
    logic       pa_req;
    logic       pb_req;
    logic [1:0] La;
    logic [1:0] Lb;
    logic       walk_a;
    logic       walk_b;
    logic [2:0] phase;

    traffic_phase_sched dut (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick),
        .Ta     (Ta),
        .Tb     (Tb),
        .pa_req (pa_req),
        .pb_req (pb_req),
        .La     (La),
        .Lb     (Lb),
        .walk_a (walk_a),
        .walk_b (walk_b),
        .phase  (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         sec;
        logic       rst_n;
        logic       tk;
        logic       ta;
        logic       tb;
        logic       pa;
        logic       pb;
        logic       chk;
        logic [2:0] ph;
        logic       wa;
        logic       wb;
    } vec_t;

    vec_t vecs[$];
    int   n_applied;
    int   n_miscomp;
    int   vec_idx;

    function automatic logic [1:0] exp_la(input logic [2:0] ph);
        case (ph)
            3'b000:  return 2'b00;
            3'b001:  return 2'b01;
            default: return 2'b10;
        endcase
    endfunction

    function automatic logic [1:0] exp_lb(input logic [2:0] ph);
        case (ph)
            3'b011:  return 2'b00;
            3'b100:  return 2'b01;
            default: return 2'b10;
        endcase
    endfunction

    // Apply one vector: drive at the falling edge, check outputs of this cycle.
    task automatic step(input vec_t v);
        @(negedge clk);
        reset  = v.rst_n;
        tick   = v.tk;
        Ta     = v.ta;
        Tb     = v.tb;
        pa_req = v.pa;
        pb_req = v.pb;
        if (v.chk) begin
            n_applied++;
            if ((phase !== v.ph) || (La !== exp_la(v.ph)) || (Lb !== exp_lb(v.ph)) ||
                (walk_a !== v.wa) || (walk_b !== v.wb)) begin
                n_miscomp++;
                $display("FAIL sec%0d vec%0d: got phase=%b La=%b Lb=%b walk_a=%b walk_b=%b, required phase=%b La=%b Lb=%b walk_a=%b walk_b=%b",
                         v.sec, vec_idx, phase, La, Lb, walk_a, walk_b,
                         v.ph, exp_la(v.ph), exp_lb(v.ph), v.wa, v.wb);
            end
        end
        vec_idx++;
    endtask

    // Queue n identical vectors into the table.
    task automatic seg(input int sec, input int n, input logic rst_n, input logic tk,
                       input logic ta, input logic tb, input logic pa, input logic pb,
                       input logic chk, input logic [2:0] ph, input logic wa, input logic wb);
        vec_t v;
        v = '{sec, rst_n, tk, ta, tb, pa, pb, chk, ph, wa, wb};
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    // Apply n identical vectors immediately.
    task automatic run(input int sec, input int n, input logic rst_n, input logic tk,
                       input logic ta, input logic tb, input logic pa, input logic pb,
                       input logic chk, input logic [2:0] ph, input logic wa, input logic wb);
        vec_t v;
        v = '{sec, rst_n, tk, ta, tb, pa, pb, chk, ph, wa, wb};
        for (int i = 0; i < n; i++) step(v);
    endtask

    initial begin
        n_applied = 0;
        n_miscomp = 0;
        vec_idx   = 0;
        reset  = 1'b0;
        tick   = 1'b0;
        Ta     = 1'b0;
        Tb     = 1'b0;
        pa_req = 1'b0;
        pb_req = 1'b0;

        // Sec 1: reset for 2 cycles, then A demand only -> A_GREEN forever.
        seg(1, 2,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
        seg(1, 40, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0);

        // Sec 2: B demand only: yellow at 6, all-red at 10, B green at 12.
        seg(2, 1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
        seg(2, 6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0);
        seg(2, 4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0);
        seg(2, 2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0);
        seg(2, 2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b011, 1'b0, 1'b0);

        // Sec 3: both roads busy: MAX_GREEN forces yellow at 13, B green at 19.
        seg(3, 1,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
        seg(3, 13, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0);
        seg(3, 4,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0);
        seg(3, 2,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0);
        seg(3, 2,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b011, 1'b0, 1'b0);

        // Sec 4: pedestrian-only demand, walk windows, pending clears.
        seg(4, 1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
        seg(4, 2,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0); // 0-1
        seg(4, 1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0); // 2 pb pulse
        seg(4, 3,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0); // 3-5
        seg(4, 4,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0); // 6-9
        seg(4, 2,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0); // 10-11
        seg(4, 4,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b011, 1'b0, 1'b1); // 12-15 walk
        seg(4, 2,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b011, 1'b0, 1'b0); // 16-17
        seg(4, 1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b011, 1'b0, 1'b0); // 18 pa pulse
        seg(4, 1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b011, 1'b0, 1'b0); // 19
        seg(4, 4,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b100, 1'b0, 1'b0); // 20-23
        seg(4, 2,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b101, 1'b0, 1'b0); // 24-25
        seg(4, 4,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0); // 26-29 walk
        seg(4, 4,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0); // 30-33 held
        seg(4, 1,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0); // 34
        seg(4, 4,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0); // 35-38
        seg(4, 2,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0); // 39-40
        seg(4, 20, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b011, 1'b0, 1'b0); // 41-60 no walk

        foreach (vecs[i]) step(vecs[i]);

        // Sec 5: reset during A_YELLOW clears state, timing and pending requests.
        run(5, 1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
        run(5, 3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0); // 0-2
        run(5, 1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0); // 3 pa during A green
        run(5, 2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0); // 4-5
        run(5, 1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0); // 6
        run(5, 1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0); // 7 reset
        run(5, 6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0); // p0-p5
        run(5, 4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0); // p6-p9
        run(5, 2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0); // p10-p11
        run(5, 14, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b011, 1'b0, 1'b0); // p12-p25 held

        // Sec 6: tick low freezes timing; schedule restarts from the first tick.
        run(6, 1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
        run(6, 20, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0);
        run(6, 6,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0);
        run(6, 4,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0);
        run(6, 2,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0);
        run(6, 2,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b011, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscomp);
        $finish;
    end

endmodule

// File: doc/traffic_phase_sched.md
Name: traffic_phase_sched

Overview:
- Timed phase scheduler for a two-road intersection: road A and road B.
- Sequences the signal heads through green, yellow and all-red phases.
- Enforces minimum and maximum green times.
- Arbitrates vehicle-sensor demand and latched pedestrian requests between the roads.
- Counts in units of an external 1-cycle `tick` enable, typically 1 Hz from a clock divider, and drives the lamp and walk outputs directly.

Parameters:
- CNT_W, 4: width of the elapsed-tick counter.
- MIN_GREEN, 5: minimum green duration, in ticks.
- MAX_GREEN, 12: green duration after which a competing demand forces a change, in ticks.
- YELLOW_T, 3: yellow duration, in ticks.
- ALLRED_T, 1: all-red clearance duration, in ticks.
- WALK_T, 4: walk indication duration at the start of a green, in ticks.
- Constraints: WALK_T ≤ MIN_GREEN ≤ MAX_GREEN ≤ 2^CNT_W−1; YELLOW_T ≥ 1; ALLRED_T ≥ 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- tick  in  1  time-base enable, single-cycle pulse
- Ta  in  1  vehicle present on road A
- Tb  in  1  vehicle present on road B
- pa_req  in  1  pedestrian request to walk with road A green (pulse or level)
- pb_req  in  1  pedestrian request to walk with road B green
- La  out  2  road A lamp: 00 GREEN, 01 YELLOW, 10 RED
- Lb  out  2  road B lamp, same encoding
- walk_a  out  1  walk indication for road A crossing
- walk_b  out  1  walk indication for road B crossing
- phase  out  3  current FSM state, for debug

Behaviour:
- One clock domain. Reset is sampled only on the rising clk edge while reset=0.
- Reset values:
  - state = A_GREEN (phase = 000)
  - elapsed = 0
  - pa_pend = pb_pend = 0
  - walk flags = 0
  - La = 00, Lb = 10, walk_a = walk_b = 0
- States and their encodings/lamps:
  - A_GREEN = 000: La = GREEN, Lb = RED
  - A_YELLOW = 001: La = YELLOW, Lb = RED
  - AB_RED = 010: both RED
  - B_GREEN = 011: La = RED, Lb = GREEN
  - B_YELLOW = 100: La = RED, Lb = YELLOW
  - BA_RED = 101: both RED
  - Illegal encodings go to A_GREEN on the next cycle, with both lamps RED while illegal.
- Lamp outputs are a Moore decode of the state register. No extra latency beyond the state register.
- elapsed counter:
  - Cleared to 0 on the cycle the state changes, whatever tick is.
  - Otherwise increments on tick and saturates at 2^CNT_W−1.
- Demand signals: demand_a = Ta | pa_pend; demand_b = Tb | pb_pend.
- Transitions, evaluated every cycle from the registered elapsed value:
  - A_GREEN → A_YELLOW when elapsed ≥ MIN_GREEN && demand_b && (!Ta || elapsed ≥ MAX_GREEN).
  - With no demand_b, A_GREEN is held indefinitely.
  - A_YELLOW → AB_RED when elapsed ≥ YELLOW_T.
  - AB_RED → B_GREEN when elapsed ≥ ALLRED_T.
  - B_GREEN → B_YELLOW: mirror of the A_GREEN rule, using demand_a and Tb.
  - B_YELLOW → BA_RED when elapsed ≥ YELLOW_T.
  - BA_RED → A_GREEN when elapsed ≥ ALLRED_T.
- Pedestrian latching:
  - pa_req=1 in any cycle sets pa_pend; pb_req likewise sets pb_pend.
  - On the cycle of the transition BA_RED → A_GREEN, walk_a_flag ← pa_pend and pa_pend is cleared. B side mirrors this.
  - A request in that same clearing cycle is dropped; clear has priority and the request counts as served.
  - A request arriving during its own green stays pending for the next green of that road.
- walk_a = 1 while state = A_GREEN && walk_a_flag && elapsed < WALK_T. walk_a_flag clears on exit from A_GREEN. B side mirrors this.
- Pending pedestrian demand alone causes a road switch (counts as demand) even with T* = 0.
- tick held low freezes all timing. Demand latching still operates.
- Reset mid-operation: next cycle is the full reset state; any walk in progress is cancelled.

Test Plan:
- Reset held low 2 cycles, then Ta=1, Tb=0, tick every cycle for 40 cycles → phase stays 000, La=00, Lb=10, walk_a=walk_b=0 throughout.
- Ta=0, Tb=1 from reset release (cycle 0), tick every cycle:
  - cycle 6: A_YELLOW (La=01)
  - cycle 10: AB_RED (both 10)
  - cycle 12: B_GREEN (Lb=00)
- Ta=1, Tb=1, tick every cycle → A_YELLOW entered at cycle 13 (MAX_GREEN forced), then B_GREEN at cycle 19.
- Ta=Tb=0, single-cycle pb_req pulse at cycle 2:
  - B_GREEN entered at cycle 12 with walk_b=1 for 4 cycles, then 0.
  - pb_pend is cleared.
  - Next B_GREEN shows walk_b=0.
- Drive the FSM into A_YELLOW, then assert reset=0 for 1 cycle → next cycle phase=000, La=00, elapsed=0, pending flags cleared.
- Ta=0, Tb=1 with tick=0 for 20 cycles → stays A_GREEN. Once tick resumes every cycle, the timing matches scenario 2 counted from the first tick.
